// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned SHA256_BLOCK_BITS = 512;
  localparam int unsigned SHA256_WORDS      = 16;
  localparam logic [7:0]  PAD_BYTE          = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    LEN,
    FULL,
    DONE
  } padState_t;

  // Padded length is len + 1 (0x80) + 8 (length field), rounded up to a
  // multiple of 64, so the block count is floor((len + 8) / 64) + 1.
  function automatic logic [31:0] num_blocks(input logic [63:0] len);
    return 32'((len + 64'd8) >> 6) + 32'd1;
  endfunction

endpackage

// File: rtl/sha256_last_word_pad.sv
// Masks the final partial message word and inserts the 0x80 pad byte
// directly after the last valid byte. nBytes == 0 passes the word through.
module sha256_last_word_pad
  import sha256_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  nBytes,
  output logic [31:0] padded
);

  // Keep the upper nBytes bytes, append the pad byte, zero the remainder.
  always_comb begin
    padded = word;
    case (nBytes)
      2'd1:    padded = {word[31:24], PAD_BYTE, 16'h0000};
      2'd2:    padded = {word[31:16], PAD_BYTE, 8'h00};
      2'd3:    padded = {word[31:8],  PAD_BYTE};
      default: padded = word;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a big-endian word stream into padded
// 512-bit blocks and hands them to the hash core one block at a time.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iStart,
  input  logic [LEN_W-1:0]             iMsgLength,
  input  logic [31:0]                  iWord,
  input  logic                         iWordValid,
  output logic                         oWordReady,
  input  logic                         iReadBlock,
  output logic [SHA256_BLOCK_BITS-1:0] oMessage,
  output logic                         oDataValid,
  output logic [31:0]                  oNumberBlock,
  output logic [31:0]                  oBlockCount,
  output logic                         oBusy,
  output logic                         oDone
);

  padState_t        state;
  padState_t        stateNext;
  logic [31:0]      buffer [SHA256_WORDS];
  logic [3:0]       idx;
  logic [LEN_W-1:0] bytesRem;
  logic [LEN_W-1:0] lenLat;
  logic [31:0]      numBlocks;
  logic [31:0]      blockCount;
  logic             padDone;
  logic             lastBlock;
  logic             doneReg;
  logic [63:0]      bitLen;
  logic [31:0]      lastWord;
  logic             wordFire;
  logic             partial;

  assign bitLen   = 64'(lenLat) << 3;
  assign partial  = bytesRem < LEN_W'(4);
  assign wordFire = iWordValid && oWordReady;

  sha256_last_word_pad u_lastWordPad (
    .word   (iWord),
    .nBytes (bytesRem[1:0]),
    .padded (lastWord)
  );

  assign oWordReady   = (state == FILL) && (bytesRem != '0);
  assign oDataValid   = (state == FULL);
  assign oBusy        = (state != IDLE) && (state != DONE);
  assign oDone        = doneReg || (state == DONE);
  assign oNumberBlock = numBlocks;
  assign oBlockCount  = blockCount;

  // Flatten the buffer: word 0 occupies the most significant 32 bits.
  always_comb begin
    oMessage = '0;
    for (int unsigned i = 0; i < SHA256_WORDS; i++) begin
      oMessage[SHA256_BLOCK_BITS-1-32*i -: 32] = buffer[i];
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic; a word written at index 15 always closes the block.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (iStart) stateNext = (iMsgLength == '0) ? PAD : FILL;
      FILL: begin
        if (wordFire) begin
          if (idx == 4'd15)                             stateNext = FULL;
          else if (partial || bytesRem == LEN_W'(4))    stateNext = PAD;
        end
      end
      PAD: begin
        if (padDone && idx == 4'd14) stateNext = LEN;
        else if (idx == 4'd15)       stateNext = FULL;
      end
      LEN:  if (idx == 4'd15) stateNext = FULL;
      FULL: begin
        if (iReadBlock) begin
          if (lastBlock)              stateNext = DONE;
          else if (bytesRem != '0)    stateNext = FILL;
          else                        stateNext = PAD;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: buffer writes, counters and padding flags.
  // padDone survives a FULL boundary, so a block closed before the length
  // fits resumes in PAD either with the 0x80 word still owed or already sent.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int unsigned i = 0; i < SHA256_WORDS; i++) buffer[i] <= '0;
      idx        <= '0;
      bytesRem   <= '0;
      lenLat     <= '0;
      numBlocks  <= '0;
      blockCount <= '0;
      padDone    <= 1'b0;
      lastBlock  <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            lenLat     <= iMsgLength;
            bytesRem   <= iMsgLength;
            numBlocks  <= num_blocks(64'(iMsgLength));
            blockCount <= '0;
            doneReg    <= 1'b0;
            padDone    <= 1'b0;
            lastBlock  <= 1'b0;
            idx        <= '0;
          end
        end
        FILL: begin
          if (wordFire) begin
            idx <= idx + 4'd1;
            if (partial) begin
              buffer[idx] <= lastWord;
              bytesRem    <= '0;
              padDone     <= 1'b1;
            end else begin
              buffer[idx] <= iWord;
              bytesRem    <= bytesRem - LEN_W'(4);
            end
          end
        end
        PAD: begin
          if (!(padDone && idx == 4'd14)) begin
            buffer[idx] <= padDone ? 32'h0000_0000 : {PAD_BYTE, 24'h000000};
            padDone     <= 1'b1;
            idx         <= idx + 4'd1;
          end
        end
        LEN: begin
          buffer[idx] <= (idx == 4'd14) ? bitLen[63:32] : bitLen[31:0];
          idx         <= idx + 4'd1;
          if (idx == 4'd15) lastBlock <= 1'b1;
        end
        FULL: begin
          if (iReadBlock) begin
            blockCount <= blockCount + 32'd1;
            for (int unsigned i = 0; i < SHA256_WORDS; i++) buffer[i] <= '0;
            idx <= '0;
          end
        end
        DONE:    doneReg <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder against a byte-level padding model.
module tb_sha256_msg_padder;

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iStart = 1'b0;
  logic [31:0]  iMsgLength = '0;
  logic [31:0]  iWord = '0;
  logic         iWordValid = 1'b0;
  logic         iReadBlock = 1'b0;
  logic         oWordReady;
  logic [511:0] oMessage;
  logic         oDataValid;
  logic [31:0]  oNumberBlock;
  logic [31:0]  oBlockCount;
  logic         oBusy;
  logic         oDone;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  logic [7:0]   msgBytes [$];

  always #5 iClk = ~iClk;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iStart       (iStart),
    .iMsgLength   (iMsgLength),
    .iWord        (iWord),
    .iWordValid   (iWordValid),
    .oWordReady   (oWordReady),
    .iReadBlock   (iReadBlock),
    .oMessage     (oMessage),
    .oDataValid   (oDataValid),
    .oNumberBlock (oNumberBlock),
    .oBlockCount  (oBlockCount),
    .oBusy        (oBusy),
    .oDone        (oDone)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic fillRandom(input int unsigned len);
    msgBytes.delete();
    repeat (len) msgBytes.push_back(8'($urandom));
  endtask

  // Drive one message from msgBytes and check every block it produces.
  task automatic runMsg(input int unsigned len, input int unsigned stall);
    logic [7:0]   pad [$];
    logic [63:0]  bl;
    logic [511:0] blk;
    logic [511:0] held;
    int unsigned  nb, nWords, wIdx, bIdx, waitCnt, cyc, extra, k;
    bit           armed;

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    for (int unsigned i = 0; i < len; i++) pad.push_back(msgBytes[i]);
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int b = 7; b >= 0; b--) pad.push_back(bl[8*b +: 8]);
    nb     = pad.size() / 64;
    nWords = (len + 3) / 4;
    wIdx = 0; bIdx = 0; waitCnt = 0; cyc = 0; extra = 0; armed = 0;
    held = '0;

    @(posedge iClk); #1;
    iStart = 1'b1;
    iMsgLength = len;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iMsgLength = $urandom;
    chk("nblocks", 512'(oNumberBlock), 512'(nb));
    chk("busy_start", 512'(oBusy), 512'(1));
    chk("done_clr", 512'(oDone), 512'(0));
    chk("bcnt_clr", 512'(oBlockCount), 512'(0));

    while (!oDone && cyc < 4000) begin
      iReadBlock = 1'b0;
      if (armed && !oDataValid) chk("dv_hold", 512'(oDataValid), 512'(1));
      if (oDataValid) begin
        if (!armed) begin
          armed = 1;
          blk = '1;
          if (bIdx < nb)
            for (int unsigned j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*bIdx + j];
          chk($sformatf("block%0d_len%0d", bIdx, len), oMessage, blk);
          chk("bcnt", 512'(oBlockCount), 512'(bIdx));
          held = oMessage;
          waitCnt = (bIdx == 0 && stall != 0) ? stall : $urandom_range(0, 3);
        end else if (stall != 0 && bIdx == 0) begin
          chk("stall_msg", oMessage, held);
          chk("stall_rdy", 512'(oWordReady), 512'(0));
        end
        if (waitCnt == 0) begin
          iReadBlock = 1'b1;
          armed = 0;
          bIdx++;
        end else begin
          waitCnt--;
        end
      end

      if (oWordReady && wIdx >= nWords) extra++;
      if (wIdx < nWords && $urandom_range(0, 3) != 0) begin
        iWordValid = 1'b1;
        for (int unsigned b = 0; b < 4; b++) begin
          k = 4*wIdx + b;
          iWord[31-8*b -: 8] = (k < len) ? msgBytes[k] : 8'($urandom);
        end
      end else if (wIdx >= nWords) begin
        iWordValid = 1'($urandom_range(0, 1));
        iWord = $urandom;
      end else begin
        iWordValid = 1'b0;
      end
      if (iWordValid && oWordReady && wIdx < nWords) wIdx++;

      @(posedge iClk); #1;
      cyc++;
    end
    iWordValid = 1'b0;
    iReadBlock = 1'b0;

    chk("timeout", 512'(cyc < 4000), 512'(1));
    chk("done", 512'(oDone), 512'(1));
    chk("busy_end", 512'(oBusy), 512'(0));
    chk("bcnt_end", 512'(oBlockCount), 512'(nb));
    chk("blocks_seen", 512'(bIdx), 512'(nb));
    chk("extra_ready", 512'(extra), 512'(0));
    @(posedge iClk); #1;
    chk("done_held", 512'(oDone), 512'(1));
  endtask

  task automatic loadAbc();
    msgBytes.delete();
    msgBytes.push_back(8'h61);
    msgBytes.push_back(8'h62);
    msgBytes.push_back(8'h63);
  endtask

  initial begin
    iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_msg", oMessage, '0);
    chk("rst_dv", 512'(oDataValid), 512'(0));
    chk("rst_nb", 512'(oNumberBlock), 512'(0));
    chk("rst_busy", 512'(oBusy), 512'(0));
    chk("rst_done", 512'(oDone), 512'(0));
    iRst_n = 1'b1;

    loadAbc();
    runMsg(3, 0);
    fillRandom(0);   runMsg(0, 0);
    fillRandom(55);  runMsg(55, 0);
    fillRandom(56);  runMsg(56, 0);
    fillRandom(64);  runMsg(64, 20);
    fillRandom(119); runMsg(119, 0);
    fillRandom(120); runMsg(120, 0);

    for (int n = 0; n < 12; n++) begin
      int unsigned len;
      len = $urandom_range(0, 200);
      fillRandom(len);
      runMsg(len, 0);
    end

    // Abort a 100-byte message part way through FILL.
    fillRandom(100);
    @(posedge iClk); #1;
    iStart = 1'b1;
    iMsgLength = 32'd100;
    @(posedge iClk); #1;
    iStart = 1'b0;
    for (int unsigned w = 0; w < 8; w++) begin
      iWordValid = 1'b1;
      iWord = {msgBytes[4*w], msgBytes[4*w+1], msgBytes[4*w+2], msgBytes[4*w+3]};
      @(posedge iClk); #1;
    end
    chk("pre_rst_busy", 512'(oBusy), 512'(1));
    #2;
    iRst_n = 1'b0;
    #1;
    chk("arst_msg", oMessage, '0);
    chk("arst_rdy", 512'(oWordReady), 512'(0));
    chk("arst_busy", 512'(oBusy), 512'(0));
    chk("arst_nb", 512'(oNumberBlock), 512'(0));
    chk("arst_dv", 512'(oDataValid), 512'(0));
    chk("arst_bcnt", 512'(oBlockCount), 512'(0));
    iWordValid = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;

    loadAbc();
    runMsg(3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
